mac_acc_nch: RTL
================

# mac_acc_nch

Parametrised, pipelined multiply-accumulate unit for the eFPGA math block with NUM_CH independent accumulators selected per operation. Each accepted operation multiplies two DATA_WIDTH operands, which can be signed or unsigned. The product is added to one channel's accumulator, or the accumulator is reloaded when the operation carries clear or round. The unit then returns a shifted, optionally rounded and saturated DATA_WIDTH result tagged with its channel. All controls travel with their operation, so a shift change never applies to the wrong result.

## Interface
- DATA_WIDTH, 16, operand and result width.
- GUARD_BITS, DATA_WIDTH/4, guard bits per operand.
- ACC_WIDTH, 2*(DATA_WIDTH+GUARD_BITS), derived (40 by default), accumulator width.
- NUM_CH, 4, number of accumulators (power of two, ≥2).
- CH_W, $clog2(NUM_CH), derived, channel index width.
- MAC_ACC_CLK  in  1  clock; all flops on rising edge.
- acc_ff_rst  in  1  asynchronous, active-high reset.
- MAC_CLK_EN  in  1  pipeline advance enable.
- MAC_IN_VALID  in  1  operation present.
- MAC_CH  in  CH_W  target channel.
- MAC_OPER_DATA  in  DATA_WIDTH  operand A.
- MAC_COEF_DATA  in  DATA_WIDTH  operand B.
- MAC_TC  in  1  1 = two's complement operands and result.
- MAC_ACC_CLEAR  in  1  accumulate onto 0.
- MAC_ACC_RND  in  1  accumulate onto rounding constant.
- MAC_OUT_SEL  in  6  right-shift amount s for the result.
- MAC_ACC_SAT  in  1  saturate the result.
- MAC_OUT_VALID  out  1  one-cycle result strobe.
- MAC_OUT_CH  out  CH_W  channel of the result.
- MAC_OUT  out  DATA_WIDTH  result.
- MAC_SAT_FLAG  out  1  result was saturated.
- MAC_SAT_STICKY  out  NUM_CH  per-channel sticky saturation.

## Operation
Pipeline stages:
- **P1 (input register).** Captures operands sign-extended to DATA_WIDTH+GUARD_BITS (sign extension only if MAC_TC, zero extension otherwise), plus CH, TC, CLEAR, RND, OUT_SEL, SAT and valid.
- **P2 (accumulate).** Computes base + A*B modulo 2^ACC_WIDTH.
  - Base is 0 if CLEAR.
  - Otherwise base is round_const(s) if RND.
  - Otherwise base is acc[CH].
  - CLEAR has priority over RND.
  - round_const(s) = 1<<(s-1) for 1≤s≤ACC_WIDTH-DATA_WIDTH, else 0.
  - The result is written to acc[CH]; the other channels are unchanged.
- **P3 (output register).** Processes the written value v.
  - s > ACC_WIDTH-DATA_WIDTH is treated as s=0, both for output selection and for the rounding constant.
  - sel = v[s+DATA_WIDTH-1:s].
  - TC not-saturated: v[ACC_WIDTH-1:s+DATA_WIDTH-1] all equal.
  - Unsigned not-saturated: v[ACC_WIDTH-1:s+DATA_WIDTH] all zero.
  - If s = ACC_WIDTH-DATA_WIDTH, the result is never saturated.
  - If SAT and saturated, the output is all ones when unsigned; when TC it is the most-negative value if v[MSB]=1, otherwise the most-positive value.
  - If SAT is low, the output is always sel and MAC_SAT_FLAG=0.

Rules:
- Back-to-back operations on the same channel see the previous accumulation; there is no hazard and no bubble.
- Mixed TC on one channel is computed bitwise with no check.
- Sticky: MAC_SAT_STICKY[c] sets when a P3 result on channel c asserts MAC_SAT_FLAG. It clears when a CLEAR operation on c is written in P2. If set and clear hit the same channel on the same edge, clear wins.

## Timing
- Reset (async, any time, including mid-operation): all accumulators, pipeline valids, MAC_OUT, MAC_OUT_CH, MAC_OUT_VALID, MAC_SAT_FLAG and MAC_SAT_STICKY go to 0. In-flight operations are discarded.
- An operation is accepted at an edge where MAC_IN_VALID=1 and MAC_CLK_EN=1.
  - acc[CH] is updated at the next enabled edge.
  - MAC_OUT, MAC_OUT_CH, MAC_SAT_FLAG and MAC_OUT_VALID are presented after the following enabled edge, giving latency 2 enabled edges.
- Throughput is one operation per enabled cycle.
- MAC_CLK_EN=0 at an edge:
  - Nothing is accepted, and all pipeline, accumulator and output data registers hold.
  - MAC_OUT_VALID clears.
  - Each accepted operation produces exactly one MAC_OUT_VALID cycle.
- Inputs are ignored when MAC_IN_VALID=0. MAC_OUT and MAC_OUT_CH hold their last values when MAC_OUT_VALID=0.

## Configuration
- QL_MAC_SAT_STICKY_EN defined: the MAC_SAT_STICKY register bank is built as described above.
- Not defined: MAC_SAT_STICKY is tied to 0, no sticky flops are built, and the port is still present. MAC_SAT_FLAG is unaffected.

## Test plan
All scenarios use default parameters.
- **Reset and clear/accumulate.**
  - Reset, then ch0 CLEAR, TC=1, s=0, 3×4: MAC_OUT=0x000C, OUT_CH=0, 2 edges after acceptance.
  - Next ch0, 0xFFFF×0x0002: MAC_OUT=0x000A.
- **Channel interleave.**
  - Back-to-back ch1 CLEAR 5×5, ch2 CLEAR 2×2, ch1 1×1: results 0x0019 (ch1), 0x0004 (ch2), 0x001A (ch1) on consecutive cycles.
- **Rounding.**
  - s=4, RND, 0x0008×0x0001: acc=0x10, MAC_OUT=0x0001.
  - Same with s=40 (out of range): MAC_OUT=0x0008.
- **Saturation.**
  - TC=1, SAT, CLEAR, s=0, 0x7FFF×0x7FFF: MAC_OUT=0x7FFF, SAT_FLAG=1, STICKY[0]=1.
  - TC=0, 0xFFFF×0xFFFF: MAC_OUT=0xFFFF.
  - TC=1, 0x8000×0x7FFF: MAC_OUT=0x8000.
  - Later CLEAR on ch0: STICKY[0]=0.
- **Stall and reset.**
  - Stall: drop MAC_CLK_EN for 3 cycles after acceptance; the result appears 2 enabled edges later, exactly once.
  - Reset: assert acc_ff_rst with 2 operations in flight; no MAC_OUT_VALID follows, and the next ch0 accumulate (no CLEAR) 1×1 returns 0x0001.

Source files
------------

// File: rtl/mac_acc_nch_if.sv
// mac_acc_nch_if: operation/result bundle between a MAC client (master) and mac_acc_nch (slave)
interface mac_acc_nch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W = $clog2(NUM_CH)
);
  logic MAC_CLK_EN;
  logic MAC_IN_VALID;
  logic [CH_W-1:0] MAC_CH;
  logic [DATA_WIDTH-1:0] MAC_OPER_DATA;
  logic [DATA_WIDTH-1:0] MAC_COEF_DATA;
  logic MAC_TC;
  logic MAC_ACC_CLEAR;
  logic MAC_ACC_RND;
  logic [5:0] MAC_OUT_SEL;
  logic MAC_ACC_SAT;
  logic MAC_OUT_VALID;
  logic [CH_W-1:0] MAC_OUT_CH;
  logic [DATA_WIDTH-1:0] MAC_OUT;
  logic MAC_SAT_FLAG;
  logic [NUM_CH-1:0] MAC_SAT_STICKY;
  modport master (
    output MAC_CLK_EN, MAC_IN_VALID, MAC_CH, MAC_OPER_DATA, MAC_COEF_DATA, MAC_TC,
           MAC_ACC_CLEAR, MAC_ACC_RND, MAC_OUT_SEL, MAC_ACC_SAT,
    input  MAC_OUT_VALID, MAC_OUT_CH, MAC_OUT, MAC_SAT_FLAG, MAC_SAT_STICKY
  );
  modport slave (
    input  MAC_CLK_EN, MAC_IN_VALID, MAC_CH, MAC_OPER_DATA, MAC_COEF_DATA, MAC_TC,
           MAC_ACC_CLEAR, MAC_ACC_RND, MAC_OUT_SEL, MAC_ACC_SAT,
    output MAC_OUT_VALID, MAC_OUT_CH, MAC_OUT, MAC_SAT_FLAG, MAC_SAT_STICKY
  );
endinterface

// File: rtl/mac_acc_nch.sv
// mac_acc_nch: NUM_CH-channel pipelined MAC (P1 capture, P2 accumulate, P3 shift/round/saturate); define QL_MAC_SAT_STICKY_EN for per-channel sticky saturation flops
module mac_acc_nch #(
  parameter int DATA_WIDTH = 16,
  parameter int GUARD_BITS = DATA_WIDTH / 4,
  parameter int NUM_CH = 4
) (
  input logic MAC_ACC_CLK,
  input logic acc_ff_rst,
  mac_acc_nch_if.slave bus
);
  localparam int ACC_WIDTH = 2 * (DATA_WIDTH + GUARD_BITS);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int EXT_W = DATA_WIDTH + GUARD_BITS;
  localparam int S_MAX = ACC_WIDTH - DATA_WIDTH;
  logic p1_v, p1_tc, p1_clr, p1_rnd, p1_sat;
  logic [CH_W-1:0] p1_ch;
  logic [EXT_W-1:0] p1_a, p1_b;
  logic [5:0] p1_s;
  logic p2_v, p2_tc, p2_sat;
  logic [CH_W-1:0] p2_ch;
  logic [5:0] p2_s;
  logic [ACC_WIDTH-1:0] p2_val;
  logic [ACC_WIDTH-1:0] acc [NUM_CH];
  logic [ACC_WIDTH-1:0] rnd_c, base, sum, hi_t, hi_u;
  logic signed [ACC_WIDTH-1:0] prod;
  logic [7:0] s_t;
  logic sat_det, sat_hit;
  logic [DATA_WIDTH-1:0] res;
  // accumulate onto the selected base, then window/range-check the value leaving P2
  always_comb begin
    rnd_c = (p1_s != 6'd0) ? {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (p1_s - 6'd1) : '0;
    base = p1_clr ? '0 : p1_rnd ? rnd_c : acc[p1_ch];
    prod = $signed(p1_a) * $signed(p1_b);
    sum = base + prod;
    s_t = {2'b0, p2_s} + 8'(DATA_WIDTH - 1);
    hi_t = $signed(p2_val) >>> s_t;
    hi_u = p2_val >> (s_t + 8'd1);
    sat_det = (p2_s != 6'(S_MAX)) && (p2_tc ? !(&hi_t || ~|hi_t) : |hi_u);
    sat_hit = p2_sat && sat_det;
    res = sat_hit ? (p2_tc ? {p2_val[ACC_WIDTH-1], {(DATA_WIDTH-1){~p2_val[ACC_WIDTH-1]}}} : '1)
                  : DATA_WIDTH'(p2_val >> p2_s);
  end
  // three-stage pipeline; every stage advances only on MAC_CLK_EN, out-of-range shifts fold to 0 at capture
  always_ff @(posedge MAC_ACC_CLK or posedge acc_ff_rst)
    if (acc_ff_rst) begin
      p1_v <= 1'b0; p1_tc <= 1'b0; p1_clr <= 1'b0; p1_rnd <= 1'b0; p1_sat <= 1'b0;
      p1_ch <= '0; p1_a <= '0; p1_b <= '0; p1_s <= '0;
      p2_v <= 1'b0; p2_tc <= 1'b0; p2_sat <= 1'b0; p2_ch <= '0; p2_s <= '0; p2_val <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      bus.MAC_OUT_VALID <= 1'b0; bus.MAC_OUT_CH <= '0; bus.MAC_OUT <= '0; bus.MAC_SAT_FLAG <= 1'b0;
    end else if (bus.MAC_CLK_EN) begin
      p1_v <= bus.MAC_IN_VALID;
      if (bus.MAC_IN_VALID) begin
        p1_a <= {{GUARD_BITS{bus.MAC_TC & bus.MAC_OPER_DATA[DATA_WIDTH-1]}}, bus.MAC_OPER_DATA};
        p1_b <= {{GUARD_BITS{bus.MAC_TC & bus.MAC_COEF_DATA[DATA_WIDTH-1]}}, bus.MAC_COEF_DATA};
        p1_ch <= bus.MAC_CH; p1_tc <= bus.MAC_TC; p1_clr <= bus.MAC_ACC_CLEAR;
        p1_rnd <= bus.MAC_ACC_RND; p1_sat <= bus.MAC_ACC_SAT;
        p1_s <= (bus.MAC_OUT_SEL > 6'(S_MAX)) ? 6'd0 : bus.MAC_OUT_SEL;
      end
      p2_v <= p1_v;
      if (p1_v) begin
        acc[p1_ch] <= sum; p2_val <= sum;
        p2_ch <= p1_ch; p2_tc <= p1_tc; p2_s <= p1_s; p2_sat <= p1_sat;
      end
      bus.MAC_OUT_VALID <= p2_v;
      if (p2_v) begin
        bus.MAC_OUT <= res; bus.MAC_OUT_CH <= p2_ch; bus.MAC_SAT_FLAG <= sat_hit;
      end
    end else
      bus.MAC_OUT_VALID <= 1'b0;
`ifdef QL_MAC_SAT_STICKY_EN
  logic [NUM_CH-1:0] sticky, set_m, clr_m;
  assign set_m = (p2_v && sat_hit) ? {{(NUM_CH-1){1'b0}}, 1'b1} << p2_ch : '0;
  assign clr_m = (p1_v && p1_clr) ? {{(NUM_CH-1){1'b0}}, 1'b1} << p1_ch : '0;
  // sticky set by a saturating result, cleared by a CLEAR entering the accumulator; clear wins on a tie
  always_ff @(posedge MAC_ACC_CLK or posedge acc_ff_rst)
    if (acc_ff_rst) sticky <= '0;
    else if (bus.MAC_CLK_EN) sticky <= (sticky | set_m) & ~clr_m;
  assign bus.MAC_SAT_STICKY = sticky;
`else
  assign bus.MAC_SAT_STICKY = '0;
`endif
endmodule
